// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Frame layout: LEN_LO, LEN_HI, 4*N data bytes, XOR checksum.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int LEN_W  = 16;
  localparam int LANE_W = 2;

  localparam logic [BYTE_W-1:0] CSUM_SEED = 8'h00;

  function automatic logic [BYTE_W-1:0] csum_step(
    input logic [BYTE_W-1:0] acc,
    input logic [BYTE_W-1:0] b
  );
    return acc ^ b;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
// master = loader side, slave = stream source / memory side.
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport slave (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles four stream bytes into a little-endian word.
// word_full pulses for one cycle with the finished word.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              res,
  input  logic              clr,
  input  logic              push,
  input  logic [BYTE_W-1:0] din,
  output logic [LANE_W-1:0] lane,
  output logic [WORD_W-1:0] word,
  output logic              word_full
);

  logic [23:0] part;

  // lane counter, partial lanes 0..2 and the completed word
  always_ff @(posedge clk) begin
    if (!res) begin
      lane      <= '0;
      part      <= '0;
      word      <= '0;
      word_full <= 1'b0;
    end else begin
      word_full <= 1'b0;
      if (clr) begin
        lane <= '0;
        part <= '0;
      end else if (push) begin
        lane <= lane + 1'b1;
        unique case (lane)
          2'd0: part[7:0]   <= din;
          2'd1: part[15:8]  <= din;
          2'd2: part[23:16] <= din;
          2'd3: begin
            word      <= {din, part};
            word_full <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a framed program image into instruction memory and holds
// the core in reset until the frame checksum has been verified.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 2**(ADDR_W-2)
) (
  input  logic          clk,
  input  logic          res,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          core_hold,
  output logic          done,
  output logic          error
);

  localparam int IDX_W = $clog2(MAX_WORDS + 1);

  state_t              state;
  state_t              state_n;
  logic [BYTE_W-1:0]   len_lo;
  logic [LEN_W-1:0]    len;
  logic [IDX_W-1:0]    idx;
  logic [BYTE_W-1:0]   xsum;
  logic [ADDR_W-1:0]   addr_q;
  logic [LANE_W-1:0]   lane;
  logic [WORD_W-1:0]   pk_word;
  logic                pk_full;
  logic                in_frame;
  logic                acc;
  logic                restart;
  logic                lane_done;
  logic                last_word;
  logic [LEN_W-1:0]    len_full;
  logic                len_ovf;

  assign in_frame  = (state == S_LEN0) || (state == S_LEN1) ||
                     (state == S_DATA) || (state == S_CSUM);
  assign bus.byte_ready = in_frame && !pk_full;
  assign acc       = bus.byte_valid && bus.byte_ready;
  assign restart   = start && ((state == S_IDLE) ||
                     (state == S_DONE) || (state == S_ERR));
  assign lane_done = acc && (state == S_DATA) && (lane == 2'd3);
  assign last_word = (LEN_W'(idx) + 1'b1) == len;
  assign len_full  = {bus.byte_data, len_lo};
  assign len_ovf   = len_full > LEN_W'(MAX_WORDS);

  assign bus.imem_we    = pk_full;
  assign bus.imem_wdata = pk_word;
  assign bus.imem_addr  = addr_q;

  assign core_hold = (state != S_DONE);
  assign done      = (state == S_DONE);
  assign error     = (state == S_ERR);

  imem_loader_byte_packer u_packer (
    .clk       (clk),
    .res       (res),
    .clr       (restart),
    .push      (acc && (state == S_DATA)),
    .din       (bus.byte_data),
    .lane      (lane),
    .word      (pk_word),
    .word_full (pk_full)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!res) state <= S_IDLE;
    else      state <= state_n;
  end

  // frame sequencing
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (start) state_n = S_LEN0;
      S_LEN0: if (acc) state_n = S_LEN1;
      S_LEN1: begin
        if (acc) begin
          if (len_ovf)             state_n = S_ERR;
          else if (len_full == '0) state_n = S_CSUM;
          else                     state_n = S_DATA;
        end
      end
      S_DATA: if (lane_done && last_word) state_n = S_CSUM;
      S_CSUM: begin
        if (acc) begin
          if (bus.byte_data == xsum) state_n = S_DONE;
          else                       state_n = S_ERR;
        end
      end
      S_DONE: if (start) state_n = S_LEN0;
      S_ERR:  if (start) state_n = S_LEN0;
      default: state_n = S_IDLE;
    endcase
  end

  // length, word index, checksum and write address
  always_ff @(posedge clk) begin
    if (!res) begin
      len_lo <= '0;
      len    <= '0;
      idx    <= '0;
      xsum   <= CSUM_SEED;
      addr_q <= '0;
    end else begin
      if (restart) begin
        idx  <= '0;
        xsum <= CSUM_SEED;
      end
      if (acc && (state == S_LEN0)) len_lo <= bus.byte_data;
      if (acc && (state == S_LEN1)) len <= len_full;
      if (acc && (state == S_DATA))
        xsum <= csum_step(xsum, bus.byte_data);
      if (lane_done) begin
        addr_q <= {idx[ADDR_W-3:0], 2'b00};
        idx    <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for the instruction-memory loader.
// Each task drives one scenario and checks its own results.
module tb_imem_loader;

  logic clk = 1'b0;
  logic res = 1'b0;
  logic start = 1'b0;
  logic core_hold;
  logic done;
  logic error;

  imem_loader_if #(.ADDR_W(10)) bus();

  imem_loader #(.ADDR_W(10)) dut (
    .clk       (clk),
    .res       (res),
    .start     (start),
    .bus       (bus.master),
    .core_hold (core_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [9:0]  waddr[$];
  logic [31:0] wdata[$];

  always @(negedge clk) begin
    if (bus.imem_we) begin
      waddr.push_back(bus.imem_addr);
      wdata.push_back(bus.imem_wdata);
    end
  end

  task automatic send_byte(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    for (int i = 0; i < 50; i++) begin
      if (bus.byte_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] f[$], input bit gap);
    bit ok;
    foreach (f[i]) begin
      send_byte(f[i], ok);
      if (!ok) begin
        total++; bad++;
        $display("FAIL byte_timeout idx=%0d got ready=0 want ready=1", i);
      end
      if (gap) @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_good(input string tag);
    repeat (2) @(negedge clk);
    total++;
    if (waddr.size() !== 2) begin
      bad++;
      $display("FAIL %s_nwr got %0d want 2", tag, waddr.size());
    end else begin
      total++;
      if (waddr[0] !== 10'h000 || wdata[0] !== 32'h00500513) begin
        bad++;
        $display("FAIL %s_w0 got %h/%h want 000/00500513",
                 tag, waddr[0], wdata[0]);
      end
      total++;
      if (waddr[1] !== 10'h004 || wdata[1] !== 32'h00A00593) begin
        bad++;
        $display("FAIL %s_w1 got %h/%h want 004/00a00593",
                 tag, waddr[1], wdata[1]);
      end
    end
    total++;
    if ({done, core_hold, error} !== 3'b100) begin
      bad++;
      $display("FAIL %s_status got d/h/e=%b want 100", tag,
               {done, core_hold, error});
    end
    total++;
    if (bus.byte_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s_ready got %b want 0", tag, bus.byte_ready);
    end
  endtask

  task automatic test_reset();
    res = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.byte_ready !== 1'b0) begin
      bad++; $display("FAIL rst_ready got %b want 0", bus.byte_ready);
    end
    total++;
    if (bus.imem_we !== 1'b0) begin
      bad++; $display("FAIL rst_we got %b want 0", bus.imem_we);
    end
    total++;
    if (core_hold !== 1'b1) begin
      bad++; $display("FAIL rst_hold got %b want 1", core_hold);
    end
    total++;
    if (done !== 1'b0 || error !== 1'b0) begin
      bad++; $display("FAIL rst_flags got %b%b want 00", done, error);
    end
    total++;
    if (bus.imem_addr !== 10'h0 || bus.imem_wdata !== 32'h0) begin
      bad++;
      $display("FAIL rst_bus got %h/%h want 0/0",
               bus.imem_addr, bus.imem_wdata);
    end
    res = 1'b1;
  endtask

  task automatic test_good();
    logic [7:0] f[$] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00,
                         8'h93, 8'h05, 8'hA0, 8'h00, 8'h70};
    waddr.delete(); wdata.delete();
    pulse_start();
    send_frame(f, 1'b0);
    check_good("good");
  endtask

  task automatic test_bad_csum();
    logic [7:0] f[$] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00,
                         8'h93, 8'h05, 8'hA0, 8'h00, 8'h71};
    waddr.delete(); wdata.delete();
    pulse_start();
    send_frame(f, 1'b0);
    repeat (2) @(negedge clk);
    total++;
    if (waddr.size() !== 2) begin
      bad++; $display("FAIL csum_nwr got %0d want 2", waddr.size());
    end
    total++;
    if ({done, core_hold, error} !== 3'b011) begin
      bad++;
      $display("FAIL csum_status got d/h/e=%b want 011",
               {done, core_hold, error});
    end
  endtask

  task automatic test_overflow();
    logic [7:0] f[$] = '{8'h01, 8'h01};
    waddr.delete(); wdata.delete();
    pulse_start();
    send_frame(f, 1'b0);
    total++;
    if (error !== 1'b1 || bus.byte_ready !== 1'b0) begin
      bad++;
      $display("FAIL ovf_err got err=%b rdy=%b want err=1 rdy=0",
               error, bus.byte_ready);
    end
    repeat (5) @(negedge clk);
    total++;
    if (waddr.size() !== 0) begin
      bad++; $display("FAIL ovf_nwr got %0d want 0", waddr.size());
    end
  endtask

  task automatic test_gaps();
    logic [7:0] f[$] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00,
                         8'h93, 8'h05, 8'hA0, 8'h00, 8'h70};
    waddr.delete(); wdata.delete();
    pulse_start();
    send_frame(f, 1'b1);
    check_good("gaps");
  endtask

  task automatic test_reset_mid();
    logic [7:0] p[$] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00};
    logic [7:0] f[$] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00,
                         8'h93, 8'h05, 8'hA0, 8'h00, 8'h70};
    waddr.delete(); wdata.delete();
    pulse_start();
    send_frame(p, 1'b0);
    res = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    res = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (waddr.size() !== 1) begin
      bad++; $display("FAIL mid_nwr got %0d want 1", waddr.size());
    end else begin
      total++;
      if (waddr[0] !== 10'h000 || wdata[0] !== 32'h00500513) begin
        bad++;
        $display("FAIL mid_w0 got %h/%h want 000/00500513",
                 waddr[0], wdata[0]);
      end
    end
    total++;
    if (core_hold !== 1'b1 || done !== 1'b0 || bus.byte_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_idle got h=%b d=%b r=%b want 1 0 0",
               core_hold, done, bus.byte_ready);
    end
    waddr.delete(); wdata.delete();
    pulse_start();
    send_frame(f, 1'b0);
    check_good("reload");
  endtask

  task automatic test_zero();
    logic [7:0] f[$] = '{8'h00, 8'h00, 8'h00};
    waddr.delete(); wdata.delete();
    pulse_start();
    send_frame(f, 1'b0);
    repeat (2) @(negedge clk);
    total++;
    if (waddr.size() !== 0) begin
      bad++; $display("FAIL zero_nwr got %0d want 0", waddr.size());
    end
    total++;
    if ({done, core_hold, error} !== 3'b100) begin
      bad++;
      $display("FAIL zero_status got d/h/e=%b want 100",
               {done, core_hold, error});
    end
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    test_reset();
    test_good();
    test_bad_csum();
    test_overflow();
    test_gaps();
    test_reset_mid();
    test_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
